// File: rtl/frame_writer.sv
// Splits a row-major RGB pixel stream into per-bit-plane writes for the
// dual-buffered, two-lane frame memory that led_driver scans out.
module frame_writer #(
    parameter int N_ROWS_MAX     = 64,
    parameter int N_COLS_MAX     = 256,
    parameter int BITDEPTH_MAX   = 8,
    parameter int CTRL_REG_WIDTH = 32,
    parameter int MEM_ADDR_WIDTH = $clog2(N_ROWS_MAX*N_COLS_MAX)-1
) (
    input  logic                        clk,
    input  logic                        ctrl_rst,
    input  logic                        ctrl_en,
    input  logic [CTRL_REG_WIDTH-1:0]   ctrl_n_rows,
    input  logic [CTRL_REG_WIDTH-1:0]   ctrl_n_cols,
    input  logic [CTRL_REG_WIDTH-1:0]   ctrl_bitdepth,
    input  logic                        rd_buffer,
    input  logic                        pix_valid,
    output logic                        pix_ready,
    input  logic                        pix_sof,
    input  logic [3*BITDEPTH_MAX-1:0]   pix_data,
    output logic                        mem_we,
    output logic                        mem_buffer,
    output logic [MEM_ADDR_WIDTH-1:0]   mem_addr,
    output logic [$clog2(BITDEPTH_MAX)-1:0] mem_bit,
    output logic [5:0]                  mem_dout,
    output logic [5:0]                  mem_wmask,
    output logic                        frame_done,
    output logic                        busy
);

    localparam int ROW_W = $clog2(N_ROWS_MAX);
    localparam int COL_W = $clog2(N_COLS_MAX);
    localparam int PL_W  = $clog2(BITDEPTH_MAX);
    localparam int BD_W  = $clog2(BITDEPTH_MAX+1);
    localparam int PIX_W = 3*BITDEPTH_MAX;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t                     state_reg;
    logic [ROW_W-1:0]           row_reg;
    logic [COL_W-1:0]           col_reg;
    logic [PL_W-1:0]            plane_reg;
    logic [PIX_W-1:0]           pix_reg;
    logic [CTRL_REG_WIDTH-1:0]  n_rows_reg;
    logic [CTRL_REG_WIDTH-1:0]  n_cols_reg;
    logic [BD_W-1:0]            bd_reg;
    logic                       wr_buf_reg;
    logic                       frame_start_reg;

    logic                       accept;
    logic                       new_frame;
    logic [BD_W-1:0]            bd_clamped;

    logic [PIX_W-1:0]           src_pix;
    logic [ROW_W-1:0]           src_row;
    logic [COL_W-1:0]           src_col;
    logic [PL_W-1:0]            src_plane;
    logic [BD_W-1:0]            src_bd;
    logic [CTRL_REG_WIDTH-1:0]  src_n_rows;
    logic                       src_buf;

    logic                       bottom;
    logic [ROW_W-1:0]           srow;
    logic [PL_W-1:0]            bit_idx;
    logic [2:0]                 rgb_bits;
    logic [MEM_ADDR_WIDTH-1:0]  wr_addr;
    logic                       last_plane;
    logic                       col_end;
    logic                       row_end;

    assign accept    = (state_reg == IDLE) && pix_ready && pix_valid;
    assign new_frame = frame_start_reg || pix_sof;

    always_comb begin
        if (ctrl_bitdepth == '0)
            bd_clamped = BD_W'(1);
        else if (ctrl_bitdepth > CTRL_REG_WIDTH'(BITDEPTH_MAX))
            bd_clamped = BD_W'(BITDEPTH_MAX);
        else
            bd_clamped = BD_W'(ctrl_bitdepth);
    end

    // Source of the next write: the incoming pixel on acceptance, otherwise
    // the latched pixel advancing to the following plane.
    always_comb begin
        src_pix    = pix_reg;
        src_row    = row_reg;
        src_col    = col_reg;
        src_plane  = plane_reg + PL_W'(1);
        src_bd     = bd_reg;
        src_n_rows = n_rows_reg;
        src_buf    = wr_buf_reg;
        if (state_reg == IDLE) begin
            src_pix   = pix_data;
            src_plane = '0;
            if (new_frame) begin
                src_row    = '0;
                src_col    = '0;
                src_bd     = bd_clamped;
                src_n_rows = ctrl_n_rows;
                src_buf    = ~rd_buffer;
            end
        end
    end

    assign bottom  = CTRL_REG_WIDTH'(src_row) >= src_n_rows;
    assign srow    = bottom ? (src_row - src_n_rows[ROW_W-1:0]) : src_row;
    assign wr_addr = MEM_ADDR_WIDTH'(srow) * MEM_ADDR_WIDTH'(N_COLS_MAX)
                   + MEM_ADDR_WIDTH'(src_col);
    // With fewer planes than input bits, plane 0 maps to the lowest kept MSB.
    assign bit_idx = PL_W'(BITDEPTH_MAX - int'(src_bd) + int'(src_plane));

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            logic [BITDEPTH_MAX-1:0] chan;
            assign chan         = src_pix[gi*BITDEPTH_MAX +: BITDEPTH_MAX];
            assign rgb_bits[gi] = chan[bit_idx];
        end
    endgenerate

    assign last_plane = (BD_W'(plane_reg) == bd_reg - BD_W'(1));
    assign col_end    = (CTRL_REG_WIDTH'(col_reg) == n_cols_reg - CTRL_REG_WIDTH'(1));
    assign row_end    = (CTRL_REG_WIDTH'(row_reg) == (n_rows_reg << 1) - CTRL_REG_WIDTH'(1));

    always_ff @(posedge clk or posedge ctrl_rst) begin
        if (ctrl_rst) begin
            state_reg       <= IDLE;
            row_reg         <= '0;
            col_reg         <= '0;
            plane_reg       <= '0;
            pix_reg         <= '0;
            n_rows_reg      <= '0;
            n_cols_reg      <= '0;
            bd_reg          <= '0;
            wr_buf_reg      <= 1'b0;
            frame_start_reg <= 1'b1;
            pix_ready       <= 1'b0;
            mem_we          <= 1'b0;
            mem_buffer      <= 1'b0;
            mem_addr        <= '0;
            mem_bit         <= '0;
            mem_dout        <= '0;
            mem_wmask       <= '0;
            frame_done      <= 1'b0;
            busy            <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        pix_reg    <= pix_data;
                        row_reg    <= src_row;
                        col_reg    <= src_col;
                        plane_reg  <= '0;
                        if (new_frame) begin
                            n_rows_reg      <= ctrl_n_rows;
                            n_cols_reg      <= ctrl_n_cols;
                            bd_reg          <= bd_clamped;
                            wr_buf_reg      <= ~rd_buffer;
                            frame_start_reg <= 1'b0;
                        end
                        state_reg  <= WRITE;
                        pix_ready  <= 1'b0;
                        busy       <= 1'b1;
                        mem_we     <= 1'b1;
                        mem_buffer <= src_buf;
                        mem_addr   <= wr_addr;
                        mem_bit    <= src_plane;
                        mem_dout   <= {rgb_bits, rgb_bits};
                        mem_wmask  <= bottom ? 6'b000111 : 6'b111000;
                    end else begin
                        pix_ready <= ctrl_en;
                    end
                end
                WRITE: begin
                    if (last_plane) begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                        mem_we    <= 1'b0;
                        pix_ready <= ctrl_en;
                        if (col_end) begin
                            col_reg <= '0;
                            if (row_end) begin
                                row_reg         <= '0;
                                frame_done      <= 1'b1;
                                frame_start_reg <= 1'b1;
                            end else begin
                                row_reg <= row_reg + ROW_W'(1);
                            end
                        end else begin
                            col_reg <= col_reg + COL_W'(1);
                        end
                    end else begin
                        plane_reg  <= src_plane;
                        mem_addr   <= wr_addr;
                        mem_bit    <= src_plane;
                        mem_dout   <= {rgb_bits, rgb_bits};
                        mem_wmask  <= bottom ? 6'b000111 : 6'b111000;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
